// File: rtl/fir_tap_buffer.sv
// Multi-channel circular sample store for the FIR datapath.
// A burst sequencer streams a channel's taps newest-first, one per cycle, with one-cycle read latency.
module fir_tap_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int NUM_CH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_in_en,
  input  logic [CW-1:0]     data_in_ch,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_in_rdy,
  input  logic              ch_clr,
  input  logic [CW-1:0]     ch_clr_ch,
  input  logic              burst_start,
  input  logic [CW-1:0]     burst_ch,
  input  logic [AW:0]       burst_len,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_vld,
  output logic [AW-1:0]     data_out_tap,
  output logic              burst_done,
  output logic              wr_drop
);

  localparam int MEM_AW = CW + AW;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [AW-1:0]     wr_ptr   [NUM_CH];
  logic [AW-1:0]     ptr_nxt  [NUM_CH];
  logic [AW:0]       fill     [NUM_CH];
  logic [AW:0]       fill_nxt [NUM_CH];

  logic              wr_ok;
  logic              accept;
  logic              issue_last;
  logic [AW:0]       len_clamp;
  logic [AW-1:0]     len_m1;
  logic [CW-1:0]     run_ch;
  logic [AW-1:0]     run_ptr;
  logic [AW:0]       run_fill;
  logic [AW-1:0]     run_last;
  logic [AW-1:0]     tap_idx;
  logic [AW-1:0]     rd_slot;

  logic [DATA_W-1:0] rd_q;
  logic              zero_q;
  logic              vld_q;
  logic              last_q;
  logic [AW-1:0]     tap_q;

  assign busy        = (state == RUN);
  assign data_in_rdy = !(busy && (data_in_ch == run_ch));
  assign wr_ok       = data_in_en && data_in_rdy && ({1'b0, data_in_ch} < (CW+1)'(NUM_CH));

  // Next pointer/fill are also what a same-cycle burst snapshots, so a
  // coincident write shows up as tap 0 and a coincident flush wins.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ptr_nxt[c]  = wr_ptr[c];
      fill_nxt[c] = fill[c];
      if (wr_ok && data_in_ch == CW'(c)) begin
        ptr_nxt[c] = wr_ptr[c] + 1'b1;
        if (fill[c] != (AW+1)'(DEPTH))
          fill_nxt[c] = fill[c] + 1'b1;
      end
      if (ch_clr && ch_clr_ch == CW'(c))
        fill_nxt[c] = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!rst_n) begin
        wr_ptr[c] <= '0;
        fill[c]   <= '0;
      end else begin
        wr_ptr[c] <= ptr_nxt[c];
        fill[c]   <= fill_nxt[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      wr_drop <= 1'b0;
    else if (data_in_en && !data_in_rdy)
      wr_drop <= 1'b1;
  end

  assign len_clamp  = (burst_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : burst_len;
  assign len_m1     = AW'(len_clamp - 1'b1);
  assign issue_last = (tap_idx == run_last);
  assign rd_slot    = run_ptr - tap_idx - 1'b1;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (burst_start && burst_len != '0 && ({1'b0, burst_ch} < (CW+1)'(NUM_CH))) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (issue_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_ch   <= '0;
      run_ptr  <= '0;
      run_fill <= '0;
      run_last <= '0;
      tap_idx  <= '0;
    end else if (accept) begin
      run_ch   <= burst_ch;
      run_ptr  <= ptr_nxt[burst_ch];
      run_fill <= fill_nxt[burst_ch];
      run_last <= len_m1;
      tap_idx  <= '0;
    end else if (busy) begin
      tap_idx  <= tap_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[{data_in_ch, wr_ptr[data_in_ch]}] <= data_in;
    if (busy)
      rd_q <= mem[{run_ch, rd_slot}];
  end

  // zero_q resets high so data_out reads 0 without clearing the RAM register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      zero_q <= 1'b1;
      tap_q  <= '0;
    end else begin
      vld_q  <= busy;
      last_q <= busy && issue_last;
      if (busy) begin
        zero_q <= ({1'b0, tap_idx} >= run_fill);
        tap_q  <= tap_idx;
      end
    end
  end

  assign data_out     = zero_q ? '0 : rd_q;
  assign data_out_vld = vld_q;
  assign data_out_tap = tap_q;
  assign burst_done   = last_q;

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Directed self-checking bench for fir_tap_buffer (DEPTH=32, NUM_CH=2, DATA_W=16).
module tb_fir_tap_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_in_en;
  logic [0:0]  data_in_ch;
  logic [15:0] data_in;
  logic        data_in_rdy;
  logic        ch_clr;
  logic [0:0]  ch_clr_ch;
  logic        burst_start;
  logic [0:0]  burst_ch;
  logic [5:0]  burst_len;
  logic        busy;
  logic [15:0] data_out;
  logic        data_out_vld;
  logic [4:0]  data_out_tap;
  logic        burst_done;
  logic        wr_drop;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] cap_data [64];
  logic [4:0]  cap_tap  [64];
  logic        cap_done [64];
  int          cap_n;
  int          cap_first;

  fir_tap_buffer #(.DATA_W(16), .DEPTH(32), .NUM_CH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_en(data_in_en), .data_in_ch(data_in_ch), .data_in(data_in), .data_in_rdy(data_in_rdy),
    .ch_clr(ch_clr), .ch_clr_ch(ch_clr_ch),
    .burst_start(burst_start), .burst_ch(burst_ch), .burst_len(burst_len), .busy(busy),
    .data_out(data_out), .data_out_vld(data_out_vld), .data_out_tap(data_out_tap),
    .burst_done(burst_done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_s(input int ch, input logic [15:0] v);
    data_in_en = 1'b1;
    data_in_ch = ch[0];
    data_in    = v;
    step();
    data_in_en = 1'b0;
  endtask

  // Launches a burst and records every valid tap until burst_done or 80 cycles.
  task automatic run_burst(input int ch, input int len);
    burst_start = 1'b1;
    burst_ch    = ch[0];
    burst_len   = 6'(len);
    step();
    burst_start = 1'b0;
    cap_n     = 0;
    cap_first = -1;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (data_out_vld) begin
        if (cap_n < 64) begin
          cap_data[cap_n] = data_out;
          cap_tap[cap_n]  = data_out_tap;
          cap_done[cap_n] = burst_done;
        end
        if (cap_n == 0) cap_first = i;
        cap_n++;
        if (burst_done) break;
      end
    end
  endtask

  task automatic test_reset();
    logic [22:0] got;
    do_reset();
    got = {busy, data_out, data_out_vld, data_out_tap[0], burst_done, wr_drop, data_in_rdy};
    n_cmp++;
    if (got !== 23'h000001) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want %h", got, 23'h000001);
    end
    n_cmp++;
    if (data_out_tap !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_tap got %0d want 0", data_out_tap);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [4];
    exp_d = '{16'd3, 16'd2, 16'd1, 16'd0};
    write_s(0, 16'd1);
    write_s(0, 16'd2);
    write_s(0, 16'd3);
    run_burst(0, 4);
    n_cmp++;
    if (cap_n !== 4) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 4", cap_n);
    end
    n_cmp++;
    if (cap_first !== 1) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 1", cap_first);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (cap_data[k] !== exp_d[k] || cap_tap[k] !== 5'(k) || cap_done[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL basic_tap%0d got d=%0d t=%0d done=%0b want d=%0d t=%0d done=%0b",
                 k, cap_data[k], cap_tap[k], cap_done[k], exp_d[k], k, (k == 3));
      end
    end
  endtask

  task automatic test_wrap_clamp();
    for (int v = 1; v <= 40; v++) write_s(1, 16'(v));
    run_burst(1, 32);
    n_cmp++;
    if (cap_n !== 32) begin
      n_fail++;
      $display("FAIL wrap_count got %0d want 32", cap_n);
    end
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (cap_data[k] !== 16'(40 - k) || cap_tap[k] !== 5'(k)) begin
        n_fail++;
        $display("FAIL wrap_tap%0d got d=%0d t=%0d want d=%0d t=%0d", k, cap_data[k], cap_tap[k], 40 - k, k);
      end
    end
    step();
    n_cmp++;
    if (data_out_vld !== 1'b0 || data_out !== 16'd9 || data_out_tap !== 5'd31) begin
      n_fail++;
      $display("FAIL hold got vld=%0b d=%0d t=%0d want vld=0 d=9 t=31", data_out_vld, data_out, data_out_tap);
    end
    run_burst(1, 40);
    n_cmp++;
    if (cap_n !== 32) begin
      n_fail++;
      $display("FAIL clamp_count got %0d want 32", cap_n);
    end
    n_cmp++;
    if (cap_data[0] !== 16'd40 || cap_data[31] !== 16'd9 || cap_done[31] !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_ends got %0d/%0d done=%0b want 40/9 done=1", cap_data[0], cap_data[31], cap_done[31]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] vld_seq;
    logic       started;
    logic [15:0] d1, d4;
    burst_start = 1'b1;
    burst_ch    = 1'b1;
    burst_len   = 6'd2;
    step();
    burst_start = 1'b0;
    started = 1'b0;
    vld_seq = '0;
    d1 = '0;
    d4 = '0;
    for (int j = 0; j < 7; j++) begin
      if (j > 0) step();
      burst_start = 1'b0;
      vld_seq[j] = data_out_vld;
      if (j == 1) d1 = data_out;
      if (j == 4) d4 = data_out;
      if (!busy && !started) begin
        started = 1'b1;
        burst_start = 1'b1;
      end
    end
    burst_start = 1'b0;
    n_cmp++;
    if (vld_seq !== 7'b0110110) begin
      n_fail++;
      $display("FAIL b2b_vld_pattern got %b want %b", vld_seq, 7'b0110110);
    end
    n_cmp++;
    if (d1 !== 16'd40 || d4 !== 16'd40) begin
      n_fail++;
      $display("FAIL b2b_data got %0d/%0d want 40/40", d1, d4);
    end
  endtask

  task automatic test_interleave();
    do_reset();
    write_s(0, 16'd100);
    write_s(1, 16'hFFFB);
    write_s(0, 16'd101);
    write_s(1, 16'hFFFA);
    run_burst(1, 2);
    n_cmp++;
    if (cap_n !== 2 || cap_data[0] !== 16'hFFFA || cap_data[1] !== 16'hFFFB) begin
      n_fail++;
      $display("FAIL interleave_ch1 got n=%0d %h %h want n=2 fffa fffb", cap_n, cap_data[0], cap_data[1]);
    end
    run_burst(0, 3);
    n_cmp++;
    if (cap_n !== 3 || cap_data[0] !== 16'd101 || cap_data[1] !== 16'd100 || cap_data[2] !== 16'd0) begin
      n_fail++;
      $display("FAIL interleave_ch0 got n=%0d %0d %0d %0d want n=3 101 100 0",
               cap_n, cap_data[0], cap_data[1], cap_data[2]);
    end
  endtask

  task automatic test_drop();
    int waited;
    n_cmp++;
    if (wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_initial got %0b want 0", wr_drop);
    end
    burst_start = 1'b1;
    burst_ch    = 1'b0;
    burst_len   = 6'd3;
    step();
    burst_start = 1'b0;
    data_in_en = 1'b1;
    data_in_ch = 1'b0;
    data_in    = 16'd999;
    #1;
    n_cmp++;
    if (data_in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_rdy_busy_ch got %0b want 0", data_in_rdy);
    end
    step();
    data_in_ch = 1'b1;
    data_in    = 16'd55;
    #1;
    n_cmp++;
    if (data_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_rdy_other_ch got %0b want 1", data_in_rdy);
    end
    step();
    data_in_en = 1'b0;
    n_cmp++;
    if (wr_drop !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_flag got %0b want 1", wr_drop);
    end
    waited = 0;
    while (busy && waited < 40) begin
      step();
      waited++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle_timeout got busy=%0b want 0", busy);
    end
    step();
    step();
    run_burst(0, 3);
    n_cmp++;
    if (cap_data[0] !== 16'd101 || cap_data[1] !== 16'd100 || cap_data[2] !== 16'd0) begin
      n_fail++;
      $display("FAIL drop_ch0_unchanged got %0d %0d %0d want 101 100 0", cap_data[0], cap_data[1], cap_data[2]);
    end
    run_burst(1, 3);
    n_cmp++;
    if (cap_data[0] !== 16'd55 || cap_data[1] !== 16'hFFFA || cap_data[2] !== 16'hFFFB) begin
      n_fail++;
      $display("FAIL drop_ch1_accepted got %h %h %h want 0037 fffa fffb", cap_data[0], cap_data[1], cap_data[2]);
    end
  endtask

  task automatic test_flush();
    for (int v = 11; v <= 18; v++) write_s(0, 16'(v));
    ch_clr    = 1'b1;
    ch_clr_ch = 1'b0;
    step();
    ch_clr = 1'b0;
    write_s(0, 16'd7);
    run_burst(0, 3);
    n_cmp++;
    if (cap_n !== 3 || cap_data[0] !== 16'd7 || cap_data[1] !== 16'd0 || cap_data[2] !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_basic got n=%0d %0d %0d %0d want n=3 7 0 0", cap_n, cap_data[0], cap_data[1], cap_data[2]);
    end
    ch_clr    = 1'b1;
    ch_clr_ch = 1'b0;
    write_s(0, 16'd9);
    ch_clr = 1'b0;
    run_burst(0, 1);
    n_cmp++;
    if (cap_n !== 1 || cap_data[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_vs_write got n=%0d d=%0d want n=1 d=0", cap_n, cap_data[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic seen;
    logic [22:0] got;
    for (int v = 1; v <= 10; v++) write_s(1, 16'(v + 200));
    burst_start = 1'b1;
    burst_ch    = 1'b1;
    burst_len   = 6'd10;
    step();
    burst_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (data_out_vld && data_out_tap == 5'd5) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_tap5_timeout got %0b want 1", seen);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    got = {busy, data_out, data_out_vld, data_out_tap[0], burst_done, wr_drop, 1'b0};
    n_cmp++;
    if (got !== 23'h0 || data_out_tap !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got %h tap=%0d want 0 tap=0", got, data_out_tap);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (burst_done || data_out_vld || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_done got activity=%0b want 0", seen);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    data_in_en  = 1'b0;
    data_in_ch  = 1'b0;
    data_in     = '0;
    ch_clr      = 1'b0;
    ch_clr_ch   = 1'b0;
    burst_start = 1'b0;
    burst_ch    = 1'b0;
    burst_len   = '0;
    test_reset();
    test_basic();
    test_wrap_clamp();
    test_back_to_back();
    test_interleave();
    test_drop();
    test_flush();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_buffer.md
Name: fir_tap_buffer

Overview:
- Parametrised multi-channel sample delay line for the FIR datapath. It is the successor of the single-channel 32x16 shift-register sample store.
- Samples are held in a circular buffer, one region per channel, addressed by per-channel write pointers. Nothing is shifted.
- An internal burst sequencer streams taps newest-first to the MAC, one per cycle. Taps not yet written read as zero.

Parameters:
DATA_W, 16, sample width in bits (two's complement)
DEPTH, 32, taps stored per channel; power of two, at least 2
NUM_CH, 2, number of interleaved channels; at least 1
Derived: AW = log2(DEPTH); CW = max(1, log2(NUM_CH))

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
data_in_en  in  1  write strobe for one sample
data_in_ch  in  CW  target channel of the write
data_in  in  DATA_W  sample to write (signed)
data_in_rdy  out  1  write accepted this cycle (combinational)
ch_clr  in  1  flush request for a channel's history
ch_clr_ch  in  CW  channel to flush
burst_start  in  1  start a tap burst
burst_ch  in  CW  channel to read
burst_len  in  AW+1  number of taps to read, 1..DEPTH
busy  out  1  burst in progress
data_out  out  DATA_W  tap sample (signed)
data_out_vld  out  1  data_out and data_out_tap valid
data_out_tap  out  AW  tap index of data_out; 0 = newest
burst_done  out  1  one-cycle pulse with the last valid tap
wr_drop  out  1  sticky flag: a write was refused; cleared only by reset

Behaviour:
- Reset (rst_n=0 at an edge): all write pointers = 0, all fill counts = 0, sequencer idle.
  - busy, data_out, data_out_vld, data_out_tap, burst_done and wr_drop all = 0.
  - RAM contents are not cleared; zero-fill hides them.
  - Reset mid-burst aborts the burst with no burst_done.
- Write path:
  - data_in_rdy = !(busy && data_in_ch == current burst channel).
  - If data_in_en && data_in_rdy: store at {ch, wr_ptr[ch]}. wr_ptr[ch] increments modulo DEPTH (wraps DEPTH-1 -> 0). fill[ch] increments, saturating at DEPTH.
  - If data_in_en && !data_in_rdy: the sample is discarded and wr_drop is set to 1.
  - data_in_ch >= NUM_CH: the write is ignored with no flag.
- Flush: ch_clr sets fill[ch_clr_ch] = 0 on the next edge; the pointer is unchanged.
  - ch_clr on the same edge as a write to that channel: the flush wins, and fill = 0 after the edge.
- Tap addressing: tap k of channel c lives at slot (wr_ptr[c] - 1 - k) mod DEPTH.
  - Tap k reads as 0 if k >= fill[c].
- Sequencer FSM, states IDLE and RUN:
  - IDLE -> RUN on burst_start when busy = 0. If busy = 1, burst_start is ignored.
  - On acceptance, latch ch = burst_ch, len = min(burst_len, DEPTH), ptr snapshot and fill snapshot.
  - burst_len = 0: no state change and no output.
  - A write to burst_ch in the same cycle as burst_start is applied first; the snapshot includes the new sample as tap 0.
  - RUN issues tap k = 0..len-1 on consecutive cycles. RUN -> IDLE after tap len-1 is issued.
- Timing for a burst accepted at edge T:
  - busy = 1 from T+1 through the cycle that issues tap len-1.
  - Tap k is read in cycle T+1+k; data_out_vld for tap k is high in cycle T+2+k (one-cycle synchronous RAM read latency).
  - burst_done coincides with data_out_vld of tap len-1.
- Back-to-back bursts: a new burst_start can be accepted in the cycle busy first reads 0. Its first tap then follows the previous burst's last tap with one idle output cycle.
- Output hold: data_out and data_out_tap hold their last values while data_out_vld = 0.

Test Plan:
- Reset, write ch0 samples 1,2,3, burst ch0 len 4 -> taps 0..3 = 3,2,1,0. data_out_vld high 4 cycles starting 2 cycles after start; burst_done on tap 3.
- Write 40 samples 1..40 to ch1 (DEPTH=32, pointer wraps), burst len 32 -> data_out runs 40 down to 9. Then burst len 40 -> clamped to 32 taps.
- Interleaved channels: ch0 gets 100,101 and ch1 gets -5,-6 (0xFFFB, 0xFFFA). Burst ch1 len 2 -> -6,-5; ch0 history is unaffected.
- During a ch0 burst, write ch0 -> data_in_rdy = 0, wr_drop = 1, and burst data is unchanged. A ch1 write in the same cycle is accepted.
- Fill ch0 with 8 samples, ch_clr ch0, write 7, burst len 3 -> 7,0,0.
- Assert rst_n = 0 during tap 5 of a len-10 burst -> all outputs 0 next cycle, busy = 0, and no burst_done.
